// File: rtl/control_circuit_if.sv
// Bus between the instruction source and the control sequencer.
// INSTRUCTION is sampled only in the fetch state; all other signals are Moore outputs of the sequencer.
interface control_circuit_if #(
  parameter int num_of_reg = 16
) ();
  logic [10:0]           INSTRUCTION;
  logic [num_of_reg-1:0] Rin;
  logic [num_of_reg-1:0] Rout;
  logic                  ALU_a_in;
  logic                  ALU_g_in;
  logic                  ALU_g_out;
  logic                  ALU_mode;
  logic                  External_load;
  logic                  Done;
  logic [1:0]            state_dbg;

  modport master (
    output INSTRUCTION,
    input  Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, ALU_mode, External_load, Done, state_dbg
  );

  modport slave (
    input  INSTRUCTION,
    output Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, ALU_mode, External_load, Done, state_dbg
  );
endinterface

// File: rtl/control_circuit.sv
// Micro-sequencer for a small register-file datapath: load, mov, add, sub.
// Fetches into IR in T0, then drives one-hot register enables and ALU controls from state and IR.
module control_circuit #(
  parameter int num_of_reg = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  control_circuit_if.slave        bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  state_t      state_q, state_d;
  logic [10:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [3:0] rx;
  logic [3:0] ry;
  logic       is_alu;

  assign opcode = ir_q[10:8];
  assign rx     = ir_q[7:4];
  assign ry     = ir_q[3:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

  function automatic logic [num_of_reg-1:0] onehot(input logic [3:0] idx);
    logic [num_of_reg-1:0] v;
    v = '0;
    for (int i = 0; i < num_of_reg; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        ir_d    = bus.INSTRUCTION;
        state_d = T1;
      end
      T1:      state_d = is_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  logic [num_of_reg-1:0] rin, rout;
  logic a_in, g_in, g_out, mode, ext_load, done;

  // Invalid opcodes fall through every case with all outputs low: a 2-cycle no-op.
  always_comb begin
    rin      = '0;
    rout     = '0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    mode     = 1'b0;
    ext_load = 1'b0;
    done     = 1'b0;
    case (state_q)
      T1: begin
        if (opcode == OP_LOAD) begin
          ext_load = 1'b1;
          rin      = onehot(rx);
          done     = 1'b1;
        end else if (opcode == OP_MOV) begin
          rout = onehot(ry);
          rin  = onehot(rx);
          done = 1'b1;
        end else if (is_alu) begin
          rout = onehot(rx);
          a_in = 1'b1;
        end
      end
      T2: begin
        if (is_alu) begin
          rout = onehot(ry);
          g_in = 1'b1;
          mode = (opcode == OP_SUB);
        end
      end
      T3: begin
        if (is_alu) begin
          g_out = 1'b1;
          rin   = onehot(rx);
          done  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.Rin           = rin;
  assign bus.Rout          = rout;
  assign bus.ALU_a_in      = a_in;
  assign bus.ALU_g_in      = g_in;
  assign bus.ALU_g_out     = g_out;
  assign bus.ALU_mode      = mode;
  assign bus.External_load = ext_load;
  assign bus.Done          = done;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_control_circuit.sv
// Directed bench for control_circuit: each task walks one instruction scenario and checks outputs cycle by cycle.
module tb_control_circuit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  control_circuit_if #(.num_of_reg(16)) bus ();

  control_circuit #(.num_of_reg(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Observed outputs packed as {Rin, Rout, a_in, g_in, g_out, mode, ext_load, done}.
  logic [37:0] obs;
  assign obs = {bus.Rin, bus.Rout, bus.ALU_a_in, bus.ALU_g_in, bus.ALU_g_out,
                bus.ALU_mode, bus.External_load, bus.Done};

  function automatic logic [37:0] pk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic a, input logic gi, input logic go,
                                     input logic m, input logic e, input logic d);
    return {rin, rout, a, gi, go, m, e, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [37:0] exp;
    reset = 1'b1;
    bus.INSTRUCTION = 11'b000_0001_0110;
    tick();
    tick();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp); end
    checks++;
    if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b000_0001_0110;
    tick();
    exp = pk(16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL load_t1 got=%h exp=%h", obs, exp); end
    bus.INSTRUCTION = 11'h7FF;
    #1;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL load_ir_held got=%h exp=%h", obs, exp); end
    bus.INSTRUCTION = 11'b000_1111_0000;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd0) begin
      errors++; $display("FAIL load_back_t0 got=%h st=%0d exp=%h st=0", obs, bus.state_dbg, exp);
    end
    tick();
    exp = pk(16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL load_r15 got=%h exp=%h", obs, exp); end
    tick();
  endtask

  task automatic test_invalid();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b10101010101;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd1) begin
      errors++; $display("FAIL invalid_t1 got=%h st=%0d exp=%h st=1", obs, bus.state_dbg, exp);
    end
    bus.INSTRUCTION = 11'b111_0000_0000;
    tick();
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd0) begin
      errors++; $display("FAIL invalid_back_t0 got=%h st=%0d exp=%h st=0", obs, bus.state_dbg, exp);
    end
    tick();
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd1) begin
      errors++; $display("FAIL invalid111_t1 got=%h st=%0d exp=%h st=1", obs, bus.state_dbg, exp);
    end
    tick();
  endtask

  task automatic test_mov();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b001_0001_0010;
    tick();
    exp = pk(16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mov_r1_r2 got=%h exp=%h", obs, exp); end
    bus.INSTRUCTION = 11'b001_0101_0101;
    tick();
    tick();
    exp = pk(16'h0020, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mov_same_reg got=%h exp=%h", obs, exp); end
    tick();
  endtask

  task automatic test_add();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b010_0011_0100;
    tick();
    exp = pk(16'h0000, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL add_t1 got=%h exp=%h", obs, exp); end
    tick();
    exp = pk(16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd2) begin
      errors++; $display("FAIL add_t2 got=%h st=%0d exp=%h st=2", obs, bus.state_dbg, exp);
    end
    tick();
    exp = pk(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL add_t3 got=%h exp=%h", obs, exp); end
    tick();
    exp = '0;
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd0) begin
      errors++; $display("FAIL add_back_t0 got=%h st=%0d exp=%h st=0", obs, bus.state_dbg, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b011_0010_0100;
    tick();
    exp = pk(16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL sub_t1 got=%h exp=%h", obs, exp); end
    tick();
    exp = pk(16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL sub_t2 got=%h exp=%h", obs, exp); end
    tick();
    exp = pk(16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL sub_t3 got=%h exp=%h", obs, exp); end
    bus.INSTRUCTION = 11'b001_1110_1111;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd0) begin
      errors++; $display("FAIL sub_next_fetch got=%h st=%0d exp=%h st=0", obs, bus.state_dbg, exp);
    end
    tick();
    exp = pk(16'h4000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mov_r14_r15 got=%h exp=%h", obs, exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [37:0] exp;
    bus.INSTRUCTION = 11'b010_0011_0100;
    tick();
    tick();
    exp = pk(16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_t2 got=%h exp=%h", obs, exp); end
    reset = 1'b1;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp || bus.state_dbg !== 2'd0) begin
      errors++; $display("FAIL rstmid_after got=%h st=%0d exp=%h st=0", obs, bus.state_dbg, exp);
    end
    reset = 1'b0;
    bus.INSTRUCTION = 11'b000_0000_1001;
    tick();
    exp = pk(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_refetch got=%h exp=%h", obs, exp); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.INSTRUCTION = '0;
    test_reset();
    test_load();
    test_invalid();
    test_mov();
    test_add();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
